// File: rtl/tcu_fedp_sequencer.sv
// -----------------------------------------------------------------------------
// tcu_fedp_sequencer
//
// Sequences one external pipelined fused dot-product unit (FEDP) over a tile
// of T output elements. Each element accumulates job_steps x N-word chunks.
// The running partial of each element is fed back into the FEDP c operand.
// The T independent chains are interleaved round-robin (step-major beat
// order). A LATENCY-deep valid/tag pipe tracks which element each in-flight
// FEDP operation belongs to. A chain whose partial has not come back yet
// blocks the operand stream, which inserts a bubble.
//
// Optional feature macro: TCU_SEQ_PERF_EN
//   defined   -> perf_issue_cnt / perf_stall_cnt are live 32-bit counters
//   undefined -> both ports are tied to 0 and no counter flops exist
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   job_*      : job request from operand fetch (fmt, steps, initial C per element)
//   op_*       : operand beats (A chunk / B chunk), valid/ready
//   fedp_*     : operands to the FEDP and its result fedp_d_val, which is
//                sampled LATENCY edges after the issuing edge
//   res_*      : final fp32 result per element to writeback, valid/ready
//   perf_*     : issue / stall counters
// -----------------------------------------------------------------------------
module tcu_fedp_sequencer #(
  parameter int N       = 2,
  parameter int T       = 4,
  parameter int LATENCY = 13,
  parameter int STEPS_W = 8,
  localparam int XLEN   = 32,
  localparam int IDX_W  = (T > 1) ? $clog2(T) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [2:0]           job_fmt_s,
  input  logic [STEPS_W-1:0]   job_steps,
  input  logic [T*XLEN-1:0]    job_c,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [N*XLEN-1:0]    op_a_row,
  input  logic [N*XLEN-1:0]    op_b_col,
  output logic                 fedp_enable,
  output logic [2:0]           fedp_fmt_s,
  output logic [N*XLEN-1:0]    fedp_a_row,
  output logic [N*XLEN-1:0]    fedp_b_col,
  output logic [XLEN-1:0]      fedp_c_val,
  input  logic [XLEN-1:0]      fedp_d_val,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_W-1:0]     res_idx,
  output logic [XLEN-1:0]      res_data,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(T - 1);

  state_t               state_q, state_d;
  logic [2:0]           fmt_q, fmt_d;
  logic [STEPS_W-1:0]   steps_q, steps_d;
  logic [STEPS_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]     t_q, t_d;
  logic [IDX_W-1:0]     i_q, i_d;
  logic [XLEN-1:0]      acc_q [T];
  logic [XLEN-1:0]      acc_d [T];
  logic [T-1:0]         inflight_q, inflight_d;
  logic [LATENCY-1:0]   vp_valid_q, vp_valid_d;
  logic [IDX_W-1:0]     vp_tag_q [LATENCY];
  logic [IDX_W-1:0]     vp_tag_d [LATENCY];
  logic [N*XLEN-1:0]    a_q, a_d;
  logic [N*XLEN-1:0]    b_q, b_d;
  logic [XLEN-1:0]      c_q, c_d;

  logic                 issue;
  logic                 retire;
  logic [IDX_W-1:0]     retire_tag;

  // op_ready looks only at the registered inflight bit, so a tag retiring this
  // cycle can be reissued no earlier than the following cycle.
  assign issue      = (state_q == S_ISSUE) && op_valid && !inflight_q[t_q];
  assign retire     = vp_valid_q[LATENCY-1];
  assign retire_tag = vp_tag_q[LATENCY-1];

  always_comb begin
    state_d    = state_q;
    fmt_d      = fmt_q;
    steps_d    = steps_q;
    k_d        = k_q;
    t_d        = t_q;
    i_d        = i_q;
    acc_d      = acc_q;
    inflight_d = inflight_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;

    // Valid/tag pipe advances every cycle; a cycle without an issue pushes a bubble.
    vp_valid_d    = '0;
    vp_valid_d[0] = issue;
    vp_tag_d      = vp_tag_q;
    vp_tag_d[0]   = t_q;
    for (int p = 1; p < LATENCY; p++) begin
      vp_valid_d[p] = vp_valid_q[p-1];
      vp_tag_d[p]   = vp_tag_q[p-1];
    end

    // Partial result comes back: park it in the accumulator, free the chain.
    if (retire) begin
      acc_d[retire_tag]      = fedp_d_val;
      inflight_d[retire_tag] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          fmt_d      = job_fmt_s;
          steps_d    = job_steps;
          for (int j = 0; j < T; j++) begin
            acc_d[j] = job_c[j*XLEN +: XLEN];
          end
          inflight_d = '0;
          t_d        = '0;
          k_d        = '0;
          i_d        = '0;
          state_d    = (job_steps == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          a_d             = op_a_row;
          b_d             = op_b_col;
          c_d             = acc_q[t_q];
          inflight_d[t_q] = 1'b1;
          if (t_q == LAST_T) begin
            t_d = '0;
            k_d = k_q + STEPS_W'(1);
            if (k_q == steps_q - STEPS_W'(1)) begin
              state_d = S_WAIT;
            end
          end else begin
            t_d = t_q + IDX_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (inflight_q == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (i_q == LAST_T) begin
            i_d     = '0;
            fmt_d   = '0;
            state_d = S_IDLE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fmt_q      <= '0;
      steps_q    <= '0;
      k_q        <= '0;
      t_q        <= '0;
      i_q        <= '0;
      inflight_q <= '0;
      vp_valid_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      for (int j = 0; j < T; j++) begin
        acc_q[j] <= '0;
      end
      for (int p = 0; p < LATENCY; p++) begin
        vp_tag_q[p] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fmt_q      <= fmt_d;
      steps_q    <= steps_d;
      k_q        <= k_d;
      t_q        <= t_d;
      i_q        <= i_d;
      inflight_q <= inflight_d;
      vp_valid_q <= vp_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      vp_tag_q   <= vp_tag_d;
    end
  end

  assign job_ready   = (state_q == S_IDLE);
  assign op_ready    = (state_q == S_ISSUE) && !inflight_q[t_q];
  assign res_valid   = (state_q == S_DRAIN);
  assign res_idx     = i_q;
  assign res_data    = (state_q == S_DRAIN) ? acc_q[i_q] : '0;
  // The FEDP never needs to be stalled: bubbles are tracked in the valid pipe.
  assign fedp_enable = 1'b1;
  assign fedp_fmt_s  = fmt_q;
  assign fedp_a_row  = a_q;
  assign fedp_b_col  = b_q;
  assign fedp_c_val  = c_q;

`ifdef TCU_SEQ_PERF_EN
  logic [31:0] perf_issue_q, perf_issue_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (issue) begin
      perf_issue_d = perf_issue_q + 32'd1;
    end
    if ((state_q == S_ISSUE) && op_valid && inflight_q[t_q]) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_issue_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_tcu_fedp_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tcu_fedp_sequencer.
// Contains a behavioural FEDP model (sum of lane products plus c, result
// sampled by the DUT LATENCY edges after issue) and a scoreboard of expected
// {res_idx, res_data} pairs. The pairs are pushed when a job is started and
// popped when the DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_tcu_fedp_sequencer;
  localparam int N       = 2;
  localparam int T       = 4;
  localparam int LATENCY = 13;
  localparam int STEPS_W = 8;
  localparam int XLEN    = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 job_valid = 1'b0;
  logic                 job_ready;
  logic [2:0]           job_fmt_s = '0;
  logic [STEPS_W-1:0]   job_steps = '0;
  logic [T*XLEN-1:0]    job_c = '0;
  logic                 op_valid = 1'b0;
  logic                 op_ready;
  logic [N*XLEN-1:0]    op_a_row = '0;
  logic [N*XLEN-1:0]    op_b_col = '0;
  logic                 fedp_enable;
  logic [2:0]           fedp_fmt_s;
  logic [N*XLEN-1:0]    fedp_a_row;
  logic [N*XLEN-1:0]    fedp_b_col;
  logic [XLEN-1:0]      fedp_c_val;
  logic [XLEN-1:0]      fedp_d_val;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [1:0]           res_idx;
  logic [XLEN-1:0]      res_data;
  logic [31:0]          perf_issue_cnt;
  logic [31:0]          perf_stall_cnt;

  tcu_fedp_sequencer #(
    .N(N), .T(T), .LATENCY(LATENCY), .STEPS_W(STEPS_W)
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_fmt_s(job_fmt_s),
    .job_steps(job_steps), .job_c(job_c),
    .op_valid(op_valid), .op_ready(op_ready), .op_a_row(op_a_row), .op_b_col(op_b_col),
    .fedp_enable(fedp_enable), .fedp_fmt_s(fedp_fmt_s), .fedp_a_row(fedp_a_row),
    .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [33:0] sb_q[$];
  logic [33:0] exp_r;
  int cyc = 0;
  int beat_cnt = 0;
  int beat_cyc [64];

  always @(posedge clk) cyc++;

  // ---------------- FEDP behavioural model ----------------
  function automatic real lane2r(input logic [2:0] fmt, input logic [15:0] h);
    logic [63:0] d;
    if (fmt == 3'd2) begin
      if (h[14:7] == 8'd0) return 0.0;
      d = {h[15], 11'(h[14:7]) + 11'd896, h[6:0], 45'd0};
    end else begin
      if (h[14:10] == 5'd0) return 0.0;
      d = {h[15], 11'(h[14:10]) + 11'd1008, h[9:0], 42'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [31:0] fedp_pipe [LATENCY-1];
  initial for (int j = 0; j < LATENCY-1; j++) fedp_pipe[j] = '0;

  always @(posedge clk) begin : fedp_model
    real s;
    s = f2r(fedp_c_val);
    for (int w = 0; w < 2*N; w++)
      s = s + lane2r(fedp_fmt_s, fedp_a_row[w*16 +: 16]) * lane2r(fedp_fmt_s, fedp_b_col[w*16 +: 16]);
    fedp_pipe[0] <= r2f(s);
    for (int j = 1; j < LATENCY-1; j++) fedp_pipe[j] <= fedp_pipe[j-1];
  end
  assign fedp_d_val = fedp_pipe[LATENCY-2];

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (reset && op_valid && op_ready) begin
      if (beat_cnt < 64) beat_cyc[beat_cnt] = cyc;
      beat_cnt++;
    end
  end

  always @(negedge clk) begin
    if (reset && res_valid && res_ready) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL result_extra idx=%0d got=%h required=none", res_idx, res_data);
      end else begin
        exp_r = sb_q.pop_front();
        if ({res_idx, res_data} !== exp_r) begin
          miscompares++;
          $display("FAIL result idx/data got=%0d/%h required=%0d/%h",
                   res_idx, res_data, exp_r[33:32], exp_r[31:0]);
        end else begin
          $display("result idx=%0d data=%h ok", res_idx, res_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_job(input logic [2:0] fmt, input logic [STEPS_W-1:0] steps,
                           input logic [T*XLEN-1:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [T*XLEN-1:0] expv,
                           input bit push);
    if (push) for (int i = 0; i < T; i++) sb_q.push_back({2'(i), expv[i*XLEN +: XLEN]});
    @(posedge clk); #1;
    beat_cnt  = 0;
    job_valid = 1'b1;
    job_fmt_s = fmt;
    job_steps = steps;
    job_c     = c;
    op_a_row  = {N{a}};
    op_b_col  = {N{b}};
    op_valid  = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    $display("job fmt=%0d steps=%0d started at cycle %0d", fmt, steps, cyc);
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb_q.size() == 0 && job_ready) && n < budget);
    timed_out = !(sb_q.size() == 0 && job_ready);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({job_ready, op_ready, res_valid, fedp_enable} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_handshake got=%b required=1001", {job_ready, op_ready, res_valid, fedp_enable});
    end
    vectors++;
    if ({res_idx, res_data} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_result got=%0d/%h required=0/0", res_idx, res_data);
    end
    vectors++;
    if ({fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val} !== '0) begin
      miscompares++;
      $display("FAIL reset_fedp fmt=%0d a=%h b=%h c=%h required=0", fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val);
    end
    vectors++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_perf got=%0d/%0d required=0/0", perf_issue_cnt, perf_stall_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_fp16_single();
    bit to;
    start_job(3'd1, 8'd1, '0, 32'h3C003C00, 32'h3C003C00, {4{32'h40800000}}, 1'b1);
    wait_idle(300, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL single_timeout sb_left=%0d required=0", sb_q.size()); end
    vectors++;
    if (beat_cnt !== 4) begin miscompares++; $display("FAIL single_beats got=%0d required=4", beat_cnt); end
  endtask

  task automatic test_fp16_steps3();
    bit to;
    logic [31:0] issue0, stall0;
    issue0 = perf_issue_cnt;
    stall0 = perf_stall_cnt;
    start_job(3'd1, 8'd3, {4{32'h3F800000}}, 32'h3C003C00, 32'h3C003C00, {4{32'h41500000}}, 1'b1);
    wait_idle(400, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL steps3_timeout sb_left=%0d required=0", sb_q.size()); end
    vectors++;
    if (beat_cnt !== 12) begin miscompares++; $display("FAIL steps3_beats got=%0d required=12", beat_cnt); end
    vectors++;
    if (beat_cyc[4] - beat_cyc[0] !== LATENCY + 1) begin
      miscompares++;
      $display("FAIL tile0_reissue_gap got=%0d required=%0d", beat_cyc[4] - beat_cyc[0], LATENCY + 1);
    end
    vectors++;
    if (beat_cyc[5] - beat_cyc[1] !== LATENCY + 1) begin
      miscompares++;
      $display("FAIL tile1_reissue_gap got=%0d required=%0d", beat_cyc[5] - beat_cyc[1], LATENCY + 1);
    end
`ifdef TCU_SEQ_PERF_EN
    vectors++;
    if (perf_stall_cnt - stall0 !== 32'd20) begin
      miscompares++;
      $display("FAIL perf_stall_delta got=%0d required=20", perf_stall_cnt - stall0);
    end
    vectors++;
    if (perf_issue_cnt - issue0 !== 32'd12) begin
      miscompares++;
      $display("FAIL perf_issue_delta got=%0d required=12", perf_issue_cnt - issue0);
    end
`else
    vectors++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL perf_tied got=%0d/%0d required=0/0 (base %0d/%0d)", perf_issue_cnt, perf_stall_cnt, issue0, stall0);
    end
`endif
  endtask

  task automatic test_steps_zero();
    bit to;
    logic [T*XLEN-1:0] c;
    c = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    start_job(3'd1, 8'd0, c, 32'h3C003C00, 32'h3C003C00, c, 1'b1);
    wait_idle(100, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL zero_timeout sb_left=%0d required=0", sb_q.size()); end
    vectors++;
    if (beat_cnt !== 0) begin miscompares++; $display("FAIL zero_beats got=%0d required=0", beat_cnt); end
  endtask

  task automatic test_bf16();
    int n, fmt_bad;
    start_job(3'd2, 8'd2, '0, 32'h40004000, 32'h3F803F80, {4{32'h41800000}}, 1'b1);
    n = 0;
    fmt_bad = 0;
    while (!(sb_q.size() == 0 && job_ready) && n < 300) begin
      @(negedge clk);
      n++;
      if (!job_ready && fedp_fmt_s !== 3'd2) fmt_bad++;
    end
    vectors++;
    if (!(sb_q.size() == 0 && job_ready)) begin
      miscompares++;
      $display("FAIL bf16_timeout sb_left=%0d required=0", sb_q.size());
    end
    vectors++;
    if (fmt_bad !== 0) begin miscompares++; $display("FAIL bf16_fmt_hold bad_cycles=%0d required=0", fmt_bad); end
  endtask

  task automatic test_backpressure();
    int n, bad, jr_bad;
    bit to;
    res_ready = 1'b0;
    start_job(3'd1, 8'd1, '0, 32'h3C003C00, 32'h3C003C00, {4{32'h40800000}}, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 200);
    vectors++;
    if (res_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain_reached got=%b required=1", res_valid); end
    bad = 0;
    jr_bad = 0;
    repeat (5) begin
      if (res_valid !== 1'b1 || res_idx !== 2'd0 || res_data !== 32'h40800000) bad++;
      if (job_ready !== 1'b0) jr_bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL bp_hold unstable_cycles=%0d required=0", bad); end
    vectors++;
    if (jr_bad !== 0) begin miscompares++; $display("FAIL bp_job_ready high_cycles=%0d required=0", jr_bad); end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle(100, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL bp_timeout sb_left=%0d required=0", sb_q.size()); end
  endtask

  task automatic test_reset_midjob();
    int n;
    bit to;
    // Aborted job: C=1.0 so the stale FEDP partials (5.0) differ from the next job's results.
    start_job(3'd1, 8'd3, {4{32'h3F800000}}, 32'h3C003C00, 32'h3C003C00, '0, 1'b0);
    n = 0;
    while (beat_cnt < 3 && n < 100) begin @(posedge clk); #1; n++; end
    op_valid = 1'b0;
    vectors++;
    if (beat_cnt !== 3) begin miscompares++; $display("FAIL midjob_beats got=%0d required=3", beat_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({job_ready, op_ready, res_valid, fedp_enable} !== 4'b1001) begin
      miscompares++;
      $display("FAIL midjob_reset_handshake got=%b required=1001", {job_ready, op_ready, res_valid, fedp_enable});
    end
    vectors++;
    if ({fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val, res_data} !== '0) begin
      miscompares++;
      $display("FAIL midjob_reset_outputs fmt=%0d a=%h c=%h res=%h required=0", fedp_fmt_s, fedp_a_row, fedp_c_val, res_data);
    end
    vectors++;
    if ({perf_issue_cnt, perf_stall_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL midjob_reset_perf got=%0d/%0d required=0/0", perf_issue_cnt, perf_stall_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    start_job(3'd1, 8'd1, '0, 32'h3C003C00, 32'h3C003C00, {4{32'h40800000}}, 1'b1);
    wait_idle(300, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL midjob_timeout sb_left=%0d required=0", sb_q.size()); end
    vectors++;
    if (beat_cnt !== 4) begin miscompares++; $display("FAIL midjob_new_beats got=%0d required=4", beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_fp16_single();
    test_fp16_steps3();
    test_steps_zero();
    test_bf16();
    test_backpressure();
    test_reset_midjob();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
